memctrl: RTL and testbench
==========================

# memctrl

Byte-serial memory controller between the pipeline and the 8-bit unified RAM bus. It arbitrates between instruction fetch (IF) and the MEM stage, and splits 1/2/4-byte requests into per-byte RAM cycles. Read bytes are reassembled little-endian; store bytes are issued one per cycle. Each requester gets a one-cycle done pulse with the result.

## Interface
- ADDR_WIDTH, 32, width of all address ports
- clk_in  in  1  clock, rising edge
- rst_n_in  in  1  asynchronous reset, active-low
- rdy_in  in  1  global ready; low = pause (see Operation)
- if_get  in  1  IF read request, level, 4 bytes
- if_address  in  ADDR_WIDTH  IF byte address
- if_done  out  1  one-cycle pulse, if_out valid
- if_out  out  32  fetched instruction
- mem_get  in  1  MEM request, level
- mem_wr  in  1  1 = store, 0 = load
- mem_address  in  ADDR_WIDTH  MEM byte address
- mem_data  in  32  store data, low mem_len bytes used
- mem_len  in  3  byte count 1/2/4
- mem_done  out  1  one-cycle pulse, mem_out valid (loads)
- mem_out  out  32  load data, zero-extended
- ram_din  in  8  RAM read data, valid one cycle after the address is sampled
- ram_dout  out  8  RAM write data
- ram_a  out  ADDR_WIDTH  RAM address
- ram_wr  out  1  RAM write enable
- io_buffer_full  in  1  UART output buffer full

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: mem_get has priority over if_get.
  - Latch the request: address, len (IF = 4), data, owner.
  - Drive ram_a = addr; for a store, also drive ram_dout = byte0 and ram_wr = 1.
  - Go to READ or WRITE. The acceptance edge is E0.
  - A requester that is not served keeps waiting.
- READ: ram_a advances one byte per edge until addr+len-1 is issued, then holds.
  - The byte issued at edge Ek is captured at edge E(k+2) into bits [8k+7:8k].
  - After the last capture, go to DONE.
- WRITE: ram_a/ram_dout advance one byte per edge; byte k = mem_data[8k+7:8k].
  - After the byte issued at E(len-1), drive ram_wr = 0 and go to DONE.
- DONE: the owner's done = 1 and its data is valid for exactly one cycle. Then return to IDLE unconditionally.
  - No request is accepted on the DONE->IDLE edge, so a stale get cannot be double-served.
- mem_len not in {1,2,4}: accepted; no RAM cycle; go straight to DONE with mem_out = 0.
- No preemption: an IF transfer in progress completes before MEM is served, and vice versa.
- IF abort: if if_get falls while serving IF before DONE, return to IDLE at the next edge. No if_done is issued and ram_wr stays 0. MEM transfers never abort.
- rdy_in low:
  - FSM, counters and outputs hold, except ram_wr is forced 0.
  - A WRITE resumes at the held byte.
  - A READ in progress restarts from byte 0 on the first edge with rdy_in high; partial data is discarded.
- Unused high bytes of mem_out/if_out are 0.

## Timing
- Load/fetch of L bytes: acceptance at E0, done visible after E(L+1).
  - LW/fetch: done after E5.
  - LB: done after E2.
- Store of L bytes: ram_wr high after E0..E(L-1), done after EL.
  - SW: done after E4.
- Minimum spacing between acceptances: L+3 edges for reads, L+2 for writes (includes the DONE and IDLE cycles).
- Outputs are registered. done does not depend combinationally on get.
- An asynchronous reset mid-transfer clears ram_wr and done immediately, with no partial done.

## Configuration
- MEMCTRL_IO_STALL_EN defined:
  - In WRITE, a byte whose address has bits [17:16] = 2'b11 is held with ram_wr = 0 while io_buffer_full is 1.
  - It is issued on the first edge where io_buffer_full is 0.
- Undefined: io_buffer_full is ignored and IO writes proceed at full rate.

## Test plan
- Fetch: RAM[0x100..0x103] = 13,05,A0,00; if_get, if_address = 0x100 -> if_done one cycle after E5, if_out = 0x00A00513; ram_wr never 1.
- LH zero-extend: RAM[0x2001..0x2002] = 34,F2; mem_get, mem_wr = 0, len = 2 -> mem_done after E3, mem_out = 0x0000F234.
- SW: mem_data = 0xDEADBEEF at 0x3000 -> ram_wr high for 4 cycles writing EF,BE,AD,DE to 0x3000..0x3003; mem_done after E4; RAM readback matches.
- Simultaneous if_get and mem_get (LB 0x10) in IDLE -> MEM served first; IF accepted only after the DONE+IDLE cycles; both results correct.
- IF abort and pause:
  - Drop if_get after E2 -> no if_done, next request served normally.
  - rdy_in low 3 cycles mid-SW -> ram_wr 0 while low, all 4 bytes written exactly once.
- With MEMCTRL_IO_STALL_EN: SB to 0x30000 with io_buffer_full = 1 for 5 cycles -> ram_wr stays 0 until io_buffer_full falls, then writes the byte; mem_done one cycle later.

Source files
------------

// File: rtl/memctrl.sv
// memctrl: byte-serial controller between IF/MEM requesters and the 8-bit unified RAM bus.
// Optional MEMCTRL_IO_STALL_EN: store bytes to the IO region (addr[17:16] == 2'b11) wait while io_buffer_full.
module memctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  if_get,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_done,
  output logic [31:0]           if_out,
  input  logic                  mem_get,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           mem_data,
  input  logic [2:0]            mem_len,
  output logic                  mem_done,
  output logic [31:0]           mem_out,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, ram_a_d, wr_addr;
  logic [2:0]            len_q, len_d, cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d, buf_q, buf_d, if_out_d, mem_out_d;
  logic                  own_if_q, own_if_d, paused_q, paused_d;
  logic                  if_done_d, mem_done_d, ram_wr_d;
  logic [7:0]            ram_dout_d;
  logic                  io_stall, mem_len_ok;

  assign mem_len_ok = (mem_len == 3'd1) || (mem_len == 3'd2) || (mem_len == 3'd4);
  // Address of the next store byte: the new request in IDLE, else the running byte.
  assign wr_addr = (state_q == IDLE) ? mem_address : addr_q + ADDR_WIDTH'(cnt_q);

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall = (wr_addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_stall  = 1'b0;
`endif

  // Next-state and registered-output logic; cnt counts edges (READ) or issued bytes (WRITE).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    own_if_d   = own_if_q;
    paused_d   = !rdy_in;
    ram_a_d    = ram_a;
    ram_dout_d = ram_dout;
    ram_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    mem_done_d = 1'b0;
    if_out_d   = if_out;
    mem_out_d  = mem_out;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (mem_get) begin
            addr_d   = mem_address;
            len_d    = mem_len;
            wdata_d  = mem_data;
            own_if_d = 1'b0;
            cnt_d    = 3'd0;
            buf_d    = 32'd0;
            ram_a_d  = mem_address;
            if (!mem_len_ok) begin
              state_d    = DONE;
              mem_done_d = 1'b1;
              mem_out_d  = 32'd0;
            end else if (mem_wr) begin
              state_d = WRITE;
              if (!io_stall) begin
                ram_dout_d = mem_data[7:0];
                ram_wr_d   = 1'b1;
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = READ;
            end
          end else if (if_get) begin
            addr_d   = if_address;
            len_d    = 3'd4;
            own_if_d = 1'b1;
            cnt_d    = 3'd0;
            buf_d    = 32'd0;
            ram_a_d  = if_address;
            state_d  = READ;
          end
        end
        READ: begin
          if (own_if_q && !if_get) begin
            state_d = IDLE;
          end else if (paused_q) begin
            // First edge after a pause: the RAM pipeline is stale, start over.
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            ram_a_d = addr_q;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < len_q) ram_a_d = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
            if (cnt_q != 3'd0) begin
              buf_d = buf_q | (32'(ram_din) << {cnt_q - 3'd1, 3'b000});
              if (cnt_q == len_q) begin
                state_d = DONE;
                if (own_if_q) begin
                  if_done_d = 1'b1;
                  if_out_d  = buf_d;
                end else begin
                  mem_done_d = 1'b1;
                  mem_out_d  = buf_d;
                end
              end
            end
          end
        end
        WRITE: begin
          if (cnt_q == len_q) begin
            state_d    = DONE;
            mem_done_d = 1'b1;
            mem_out_d  = 32'd0;
          end else begin
            ram_a_d = wr_addr;
            if (!io_stall) begin
              ram_dout_d = 8'(wdata_q >> {cnt_q, 3'b000});
              ram_wr_d   = 1'b1;
              cnt_d      = cnt_q + 3'd1;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= 3'd0;
      cnt_q    <= 3'd0;
      wdata_q  <= 32'd0;
      buf_q    <= 32'd0;
      own_if_q <= 1'b0;
      paused_q <= 1'b0;
      ram_a    <= '0;
      ram_dout <= 8'd0;
      ram_wr   <= 1'b0;
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if_out   <= 32'd0;
      mem_out  <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      own_if_q <= own_if_d;
      paused_q <= paused_d;
      ram_a    <= ram_a_d;
      ram_dout <= ram_dout_d;
      ram_wr   <= ram_wr_d;
      if_done  <= if_done_d;
      mem_done <= mem_done_d;
      if_out   <= if_out_d;
      mem_out  <= mem_out_d;
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: directed and randomized transfers against a byte-array RAM and a reference memory image.
module tb_memctrl;
  localparam int unsigned MW = 18;

  logic        clk, rst_n, rdy_in, if_get, if_done, mem_get, mem_wr, mem_done, ram_wr, io_buffer_full;
  logic [31:0] if_address, if_out, mem_address, mem_data, mem_out, ram_a;
  logic [2:0]  mem_len;
  logic [7:0]  ram_din, ram_dout;

  logic [7:0]  ram     [0:2**MW-1];
  logic [7:0]  ref_mem [0:2**MW-1];
  int          n_checks, n_errors;

  memctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in),
    .if_get(if_get), .if_address(if_address), .if_done(if_done), .if_out(if_out),
    .mem_get(mem_get), .mem_wr(mem_wr), .mem_address(mem_address), .mem_data(mem_data),
    .mem_len(mem_len), .mem_done(mem_done), .mem_out(mem_out),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] preload_byte(input int i);
    case (i)
      'h100: return 8'h13;
      'h101: return 8'h05;
      'h102: return 8'hA0;
      'h103: return 8'h00;
      'h2001: return 8'h34;
      'h2002: return 8'hF2;
      default: return 8'((i * 37 + (i >> 8) * 11) ^ 'h5a);
    endcase
  endfunction

  // RAM: address sampled at an edge, data out after it; writes on edges with ram_wr high.
  initial begin
    ram_din = 8'd0;
    for (int i = 0; i < 2**MW; i++) ram[i] = preload_byte(i);
    forever begin
      @(posedge clk);
      ram_din <= ram[ram_a[MW-1:0]];
      if (ram_wr) ram[ram_a[MW-1:0]] <= ram_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input int len);
    logic [31:0] v, a;
    v = 32'd0;
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(i);
      v[8*i +: 8] = ref_mem[a[MW-1:0]];
    end
    return v;
  endfunction

  // Edges from request to visible done (acceptance edge counts as 1); pause of n edges starting at edge p+1.
  function automatic int exp_lat(input bit wr, input int len, input int p, input int n);
    if (!(len == 1 || len == 2 || len == 4)) return 1;
    if (wr) return len + 1 + n;
    if (n == 0) return len + 2;
    return p + n + len + 2;
  endfunction

  task automatic run_req(input string tag, input bit is_if, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input int len, input int p, input int n);
    int k, wr_cnt, exp_k, eff_len;
    bit seen, ok_len, st;
    logic [31:0] exp_v, a;
    eff_len = is_if ? 4 : len;
    st      = wr && !is_if;
    ok_len  = (eff_len == 1) || (eff_len == 2) || (eff_len == 4);
    exp_k   = exp_lat(st, eff_len, p, n);
    exp_v   = (ok_len && !st) ? ref_read(addr, eff_len) : 32'd0;
    if (is_if) begin
      if_get = 1'b1; if_address = addr;
    end else begin
      mem_get = 1'b1; mem_wr = wr; mem_address = addr; mem_data = data; mem_len = 3'(len);
    end
    k = 0; seen = 0; wr_cnt = 0;
    while (!seen && k < 60) begin
      @(posedge clk); #1; k++;
      if (ram_wr) wr_cnt++;
      if (n > 0 && k > p && k <= p + n) chk({tag, " wr_in_pause"}, 32'(ram_wr), 32'd0);
      if (n > 0 && k == p) rdy_in = 1'b0;
      if (n > 0 && k == p + n) rdy_in = 1'b1;
      seen = is_if ? if_done : mem_done;
    end
    if_get = 1'b0; mem_get = 1'b0;
    if (!seen) begin
      rdy_in = 1'b1;
      chk({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " latency"}, 32'(k), 32'(exp_k));
      if (!st) chk({tag, " data"}, is_if ? if_out : mem_out, exp_v);
      chk({tag, " other_done"}, 32'(is_if ? mem_done : if_done), 32'd0);
      chk({tag, " wr_cycles"}, 32'(wr_cnt), (st && ok_len) ? 32'(len) : 32'd0);
      if (st && ok_len) begin
        for (int i = 0; i < len; i++) begin
          a = addr + 32'(i);
          ref_mem[a[MW-1:0]] = data[8*i +: 8];
          chk({tag, " readback"}, 32'(ram[a[MW-1:0]]), 32'(ref_mem[a[MW-1:0]]));
        end
      end
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 32'(is_if ? if_done : mem_done), 32'd0);
    end
  endtask

  initial begin
    int km, ki, cnt_done, cnt_wr, kind, len, p, n, first_wr;
    logic [31:0] addr, data, old_b;
    bit seen;
    n_checks = 0; n_errors = 0;
    for (int i = 0; i < 2**MW; i++) ref_mem[i] = preload_byte(i);
    rst_n = 1'b0; rdy_in = 1'b1; if_get = 1'b0; if_address = 32'd0; mem_get = 1'b0;
    mem_wr = 1'b0; mem_address = 32'd0; mem_data = 32'd0; mem_len = 3'd0; io_buffer_full = 1'b0;

    #12;
    chk("rst if_done", 32'(if_done), 32'd0);
    chk("rst mem_done", 32'(mem_done), 32'd0);
    chk("rst ram_wr", 32'(ram_wr), 32'd0);
    chk("rst ram_a", ram_a, 32'd0);
    chk("rst ram_dout", 32'(ram_dout), 32'd0);
    chk("rst if_out", if_out, 32'd0);
    chk("rst mem_out", mem_out, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("fetch", 1, 0, 32'h100, 32'd0, 4, 0, 0);
    chk("fetch value", if_out, 32'h00A00513);
    run_req("lh", 0, 0, 32'h2001, 32'd0, 2, 0, 0);
    chk("lh value", mem_out, 32'h0000F234);
    run_req("sw", 0, 1, 32'h3000, 32'hDEADBEEF, 4, 0, 0);
    run_req("sw_rd", 0, 0, 32'h3000, 32'd0, 4, 0, 0);
    chk("sw_rd value", mem_out, 32'hDEADBEEF);

    // Simultaneous requests: MEM first, IF after DONE and IDLE cycles.
    if_get = 1'b1; if_address = 32'h200;
    mem_get = 1'b1; mem_wr = 1'b0; mem_address = 32'h10; mem_len = 3'd1;
    km = 0; ki = 0;
    for (int k = 1; k <= 30 && ki == 0; k++) begin
      @(posedge clk); #1;
      if (mem_done && km == 0) begin
        km = k; mem_get = 1'b0;
        chk("arb mem_out", mem_out, ref_read(32'h10, 1));
      end
      if (if_done) begin
        ki = k; if_get = 1'b0;
        chk("arb if_out", if_out, ref_read(32'h200, 4));
      end
    end
    if_get = 1'b0; mem_get = 1'b0;
    chk("arb mem_lat", 32'(km), 32'd3);
    chk("arb if_lat", 32'(ki), 32'd10);
    @(posedge clk); #1;

    // IF abort after E2.
    if_get = 1'b1; if_address = 32'h300;
    cnt_done = 0; cnt_wr = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (if_done) cnt_done++;
      if (ram_wr) cnt_wr++;
      if (k == 3) if_get = 1'b0;
    end
    chk("abort if_done", 32'(cnt_done), 32'd0);
    chk("abort ram_wr", 32'(cnt_wr), 32'd0);
    run_req("post_abort", 1, 0, 32'h304, 32'd0, 4, 0, 0);

    run_req("sw_pause", 0, 1, 32'h4000, 32'h11223344, 4, 2, 3);
    run_req("lw_pause", 0, 0, 32'h4000, 32'd0, 4, 3, 2);
    chk("lw_pause value", mem_out, 32'h11223344);
    run_req("bad_ld", 0, 0, 32'h100, 32'd0, 3, 0, 0);
    run_req("bad_st", 0, 1, 32'h5000, 32'hCAFEF00D, 0, 0, 0);
    run_req("sb", 0, 1, 32'h5001, 32'h000000A5, 1, 0, 0);
    run_req("lw_sb", 0, 0, 32'h5000, 32'd0, 4, 0, 0);

    // IO-region byte store while the UART buffer is full for five edges.
    mem_get = 1'b1; mem_wr = 1'b1; mem_address = 32'h30000; mem_data = 32'h0000003C; mem_len = 3'd1;
    io_buffer_full = 1'b1;
    km = 0; first_wr = 0; cnt_wr = 0; seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (ram_wr) begin
        cnt_wr++;
        if (first_wr == 0) first_wr = k;
      end
      if (k == 5) io_buffer_full = 1'b0;
      if (mem_done) begin seen = 1; km = k; end
    end
    mem_get = 1'b0; io_buffer_full = 1'b0;
`ifdef MEMCTRL_IO_STALL_EN
    chk("io first_wr", 32'(first_wr), 32'd6);
    chk("io done_lat", 32'(km), 32'd7);
`else
    chk("io first_wr", 32'(first_wr), 32'd1);
    chk("io done_lat", 32'(km), 32'd2);
`endif
    chk("io wr_cycles", 32'(cnt_wr), 32'd1);
    ref_mem['h30000] = 8'h3C;
    chk("io readback", 32'(ram['h30000]), 32'h3C);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a store.
    old_b = 32'(ram['h2F001]);
    mem_get = 1'b1; mem_wr = 1'b1; mem_address = 32'h2F000; mem_data = 32'h87654321; mem_len = 3'd4;
    @(posedge clk); #1;
    chk("arst pre ram_wr", 32'(ram_wr), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0; mem_get = 1'b0;
    #1;
    chk("arst ram_wr", 32'(ram_wr), 32'd0);
    chk("arst mem_done", 32'(mem_done), 32'd0);
    chk("arst ram_a", ram_a, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst byte0", 32'(ram['h2F000]), 32'h21);
    chk("arst byte1", 32'(ram['h2F001]), old_b);
    ref_mem['h2F000] = 8'h21;

    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 'h1FFF0));
      data = $urandom;
      p = 0; n = 0;
      if (kind <= 1) begin
        len = 4;
      end else if (kind <= 6) begin
        len = (kind % 3 == 0) ? 1 : ((kind % 3 == 1) ? 2 : 4);
      end else begin
        len = (($urandom_range(0, 1) == 0) ? 3 : 0);
      end
      if (kind <= 6 && $urandom_range(0, 3) == 0) begin
        n = int'($urandom_range(1, 3));
        p = int'($urandom_range(1, (kind >= 5) ? len : len + 1));
      end
      run_req($sformatf("rnd%0d", t), kind <= 1, (kind >= 5 && kind <= 6) || (kind == 7 && t[0]),
              addr, data, len, p, n);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
